// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: default parameters,
// FSM state encoding and a modular index helper.
package uart_pkg;

  localparam int NUM_REQ_DEFAULT      = 2;
  localparam int BUSY_TIMEOUT_DEFAULT = 8;

  // FSM encoding kept as plain constants so older tools can read it.
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ISSUE     = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  // Next requester index, wrapping at n (works for any n, not just 2^k).
  function automatic int wrap_next(input int idx, input int n);
    if (idx + 32'sd1 >= n) begin
      return 32'sd0;
    end else begin
      return idx + 32'sd1;
    end
  endfunction

endpackage

// File: rtl/rr_select.sv
// Round-robin picker: first set bit of req_i at or after ptr_i, wrapping
// modulo N. Purely combinational; N need not be a power of two.
module rr_select #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  // Candidate index for the current search position (ptr + offset, wrapped).
  logic [IW:0] cand_s;

  // Walk the requesters starting at ptr_i and take the first one asking.
  always_comb begin
    gnt_o  = '0;
    idx_o  = '0;
    any_o  = 1'b0;
    cand_s = '0;
    for (int i = 0; i < N; i++) begin
      cand_s = {1'b0, ptr_i} + (IW+1)'(i);
      if (cand_s >= (IW+1)'(N)) begin
        cand_s = cand_s - (IW+1)'(N);
      end else begin
        cand_s = cand_s;
      end
      if (!any_o && req_i[cand_s[IW-1:0]]) begin
        gnt_o[cand_s[IW-1:0]] = 1'b1;
        idx_o                 = cand_s[IW-1:0];
        any_o                 = 1'b1;
      end else begin
        any_o = any_o;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte sources. Packets (bytes up
// to req_last) are kept contiguous by locking the channel to the owner; a
// transmitter that never reports busy is abandoned after BUSY_TIMEOUT cycles.
module uart_tx_arbiter import uart_pkg::*; #(
  parameter int NUM_REQ      = NUM_REQ_DEFAULT,
  parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEFAULT,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW = $clog2(BUSY_TIMEOUT + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  input  logic                 tx_done,
  output logic [IW-1:0]        grant_id,
  output logic                 locked,
  output logic                 timeout_err
);

  logic [1:0]    state_q,    state_d;
  logic [IW-1:0] rr_ptr_q,   rr_ptr_d;
  logic [IW-1:0] grant_id_q, grant_id_d;
  logic          locked_q,   locked_d;
  logic          last_q,     last_d;
  logic [7:0]    tx_data_q,  tx_data_d;
  logic          tx_start_q, tx_start_d;
  logic          timeout_q,  timeout_d;
  logic [CW-1:0] cnt_q,      cnt_d;

  logic [NUM_REQ-1:0] rr_gnt_s;
  logic [IW-1:0]      rr_idx_s;
  logic               rr_any_s;
  logic [NUM_REQ-1:0] lock_mask_s;
  logic [NUM_REQ-1:0] req_ready_s;
  logic               accept_s;
  logic [7:0]         sel_data_s;
  logic               sel_last_s;
  logic [IW-1:0]      sel_idx_s;
  logic [IW-1:0]      owner_next_s;

  rr_select #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_select (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (rr_gnt_s),
    .idx_o (rr_idx_s),
    .any_o (rr_any_s)
  );

  // One-hot mask of the current owner, used while a packet holds the channel.
  always_comb begin
    lock_mask_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      lock_mask_s[i] = (grant_id_q == IW'(i));
    end
  end

  // Byte-accept strobe: only in IDLE, only for the owner when locked.
  always_comb begin
    req_ready_s = '0;
    if (!rst && (state_q == ST_IDLE)) begin
      if (locked_q) begin
        req_ready_s = req_valid & lock_mask_s;
      end else if (rr_any_s) begin
        req_ready_s = rr_gnt_s;
      end else begin
        req_ready_s = '0;
      end
    end else begin
      req_ready_s = '0;
    end
  end

  assign accept_s     = |req_ready_s;
  assign sel_idx_s    = locked_q ? grant_id_q : rr_idx_s;
  assign owner_next_s = IW'(wrap_next(int'(grant_id_q), NUM_REQ));

  // Pick the accepted byte and its last flag through the one-hot strobe.
  always_comb begin
    sel_data_s = 8'h00;
    sel_last_s = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready_s[i]) begin
        sel_data_s = sel_data_s | req_data[8*i +: 8];
        sel_last_s = sel_last_s | req_last[i];
      end else begin
        sel_data_s = sel_data_s;
      end
    end
  end

  // Next-state logic for the issue/busy/done handshake with the transmitter.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    locked_d   = locked_q;
    last_d     = last_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    timeout_d  = timeout_q;
    cnt_d      = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          tx_data_d  = sel_data_s;
          last_d     = sel_last_s;
          grant_id_d = sel_idx_s;
          tx_start_d = 1'b1;
          state_d    = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        // A tx_done here belongs to an earlier byte and is deliberately ignored.
        if (tx_busy) begin
          cnt_d   = '0;
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
          cnt_d     = '0;
          timeout_d = 1'b1;
          locked_d  = 1'b0;
          rr_ptr_d  = owner_next_s;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (tx_done) begin
          state_d = ST_IDLE;
          if (last_q) begin
            locked_d = 1'b0;
            rr_ptr_d = owner_next_s;
          end else begin
            locked_d = 1'b1;
          end
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset abandons any byte in flight and drops the lock.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      locked_q   <= 1'b0;
      last_q     <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      timeout_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      locked_q   <= locked_d;
      last_q     <= last_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      timeout_q  <= timeout_d;
      cnt_q      <= cnt_d;
    end
  end

  assign req_ready   = req_ready_s;
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign grant_id    = grant_id_q;
  assign locked      = locked_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NUM_REQ=2, BUSY_TIMEOUT=8) with the
// transmitter handshake driven by hand.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        tx_done;
  logic [0:0]  grant_id;
  logic        locked;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(
    .NUM_REQ      (2),
    .BUSY_TIMEOUT (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .grant_id    (grant_id),
    .locked      (locked),
    .timeout_err (timeout_err)
  );

  // 100 MHz free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs follow newly driven inputs.
  task automatic settle();
    #1;
  endtask

  // From ISSUE: one busy cycle, one done pulse, back to IDLE.
  task automatic serve();
    cyc();
    chk("start_single_cycle", {31'd0, tx_start}, 32'd0);
    tx_busy = 1'b1;
    cyc();
    tx_busy = 1'b0;
    tx_done = 1'b1;
    cyc();
    tx_done = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 2'b00;
    req_data  = 16'h0000;
    req_last  = 2'b00;
    tx_busy   = 1'b0;
    tx_done   = 1'b0;
    cyc();
    cyc();
    chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'h00);
    chk("rst_grant", {31'd0, grant_id}, 32'd0);
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_timeout", {31'd0, timeout_err}, 32'd0);
    rst = 1'b0;
    cyc();
    chk("idle_no_ready", {30'd0, req_ready}, 32'd0);

    // Single-byte packet from requester 0.
    req_data  = 16'h0055;
    req_last  = 2'b01;
    req_valid = 2'b01;
    settle();
    chk("t1_ready_same_cycle", {30'd0, req_ready}, 32'd1);
    cyc();
    chk("t1_tx_start", {31'd0, tx_start}, 32'd1);
    chk("t1_tx_data", {24'd0, tx_data}, 32'h55);
    chk("t1_grant", {31'd0, grant_id}, 32'd0);
    chk("t1_ready_issue", {30'd0, req_ready}, 32'd0);
    chk("t1_locked_issue", {31'd0, locked}, 32'd0);
    req_valid = 2'b00;
    serve();
    chk("t1_locked_after", {31'd0, locked}, 32'd0);
    chk("t1_data_stable", {24'd0, tx_data}, 32'h55);

    // Contention from rr_ptr=0: grants 0,1,0.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    req_data  = 16'h2010;
    req_last  = 2'b11;
    req_valid = 2'b11;
    settle();
    chk("t2_ready_first", {30'd0, req_ready}, 32'd1);
    cyc();
    chk("t2_grant_a", {31'd0, grant_id}, 32'd0);
    chk("t2_data_a", {24'd0, tx_data}, 32'h10);
    chk("t2_start_a", {31'd0, tx_start}, 32'd1);
    chk("t2_ready_busy", {30'd0, req_ready}, 32'd0);
    serve();
    chk("t2_ready_second", {30'd0, req_ready}, 32'd2);
    cyc();
    chk("t2_grant_b", {31'd0, grant_id}, 32'd1);
    chk("t2_data_b", {24'd0, tx_data}, 32'h20);
    serve();
    chk("t2_ready_third", {30'd0, req_ready}, 32'd1);
    cyc();
    chk("t2_grant_c", {31'd0, grant_id}, 32'd0);
    chk("t2_data_c", {24'd0, tx_data}, 32'h10);
    serve();
    req_valid = 2'b00;

    // Packet lock: requester 1 sends A1,A2,A3 while requester 0 waits.
    req_data  = 16'hA130;
    req_last  = 2'b01;
    req_valid = 2'b11;
    settle();
    chk("t3_ready_r1", {30'd0, req_ready}, 32'd2);
    cyc();
    chk("t3_data_a1", {24'd0, tx_data}, 32'hA1);
    chk("t3_grant_a1", {31'd0, grant_id}, 32'd1);
    serve();
    chk("t3_locked_a1", {31'd0, locked}, 32'd1);
    chk("t3_ready_locked", {30'd0, req_ready}, 32'd2);
    req_data = 16'hA230;
    cyc();
    chk("t3_data_a2", {24'd0, tx_data}, 32'hA2);
    serve();
    chk("t3_locked_a2", {31'd0, locked}, 32'd1);
    req_data = 16'hA330;
    req_last = 2'b11;
    cyc();
    chk("t3_data_a3", {24'd0, tx_data}, 32'hA3);
    serve();
    chk("t3_unlocked", {31'd0, locked}, 32'd0);
    chk("t3_ready_r0", {30'd0, req_ready}, 32'd1);
    cyc();
    chk("t3_grant_r0", {31'd0, grant_id}, 32'd0);
    chk("t3_data_r0", {24'd0, tx_data}, 32'h30);
    req_valid = 2'b00;
    serve();

    // Stale tx_done in the first WAIT_BUSY cycle must be ignored.
    req_data  = 16'h0077;
    req_last  = 2'b01;
    req_valid = 2'b01;
    settle();
    chk("t4_ready", {30'd0, req_ready}, 32'd1);
    cyc();
    req_valid = 2'b00;
    cyc();
    tx_done = 1'b1;
    cyc();
    tx_done   = 1'b0;
    req_valid = 2'b01;
    settle();
    chk("t4_stale_done_ignored", {30'd0, req_ready}, 32'd0);
    tx_busy = 1'b1;
    cyc();
    tx_busy = 1'b0;
    cyc();
    chk("t4_wait_fresh_done", {30'd0, req_ready}, 32'd0);
    tx_done = 1'b1;
    cyc();
    tx_done = 1'b0;
    chk("t4_idle_after_done", {30'd0, req_ready}, 32'd1);
    chk("t4_data", {24'd0, tx_data}, 32'h77);
    req_valid = 2'b00;

    // Timeout mid-packet: lock drops, pointer moves past the owner.
    req_data  = 16'h9100;
    req_last  = 2'b00;
    req_valid = 2'b10;
    settle();
    chk("t5_ready_r1", {30'd0, req_ready}, 32'd2);
    cyc();
    req_valid = 2'b00;
    serve();
    chk("t5_locked", {31'd0, locked}, 32'd1);
    req_data  = 16'h9200;
    req_valid = 2'b10;
    settle();
    cyc();
    chk("t5_data_92", {24'd0, tx_data}, 32'h92);
    req_valid = 2'b00;
    cyc();
    for (int k = 0; k < 7; k++) begin
      cyc();
      chk("t5_no_timeout_yet", {31'd0, timeout_err}, 32'd0);
    end
    cyc();
    chk("t5_timeout_set", {31'd0, timeout_err}, 32'd1);
    chk("t5_lock_cleared", {31'd0, locked}, 32'd0);
    req_data  = 16'h9355;
    req_last  = 2'b11;
    req_valid = 2'b11;
    settle();
    chk("t5_idle_ptr_r0", {30'd0, req_ready}, 32'd1);
    cyc();
    chk("t5_grant_r0", {31'd0, grant_id}, 32'd0);
    chk("t5_data_55", {24'd0, tx_data}, 32'h55);
    req_valid = 2'b00;
    serve();
    chk("t5_timeout_sticky", {31'd0, timeout_err}, 32'd1);

    // Reset while in WAIT_DONE with the channel locked.
    req_data  = 16'hB100;
    req_last  = 2'b00;
    req_valid = 2'b10;
    settle();
    cyc();
    req_valid = 2'b00;
    serve();
    req_data  = 16'hB200;
    req_valid = 2'b10;
    settle();
    cyc();
    req_valid = 2'b00;
    cyc();
    tx_busy = 1'b1;
    cyc();
    chk("t6_locked_pre", {31'd0, locked}, 32'd1);
    chk("t6_grant_pre", {31'd0, grant_id}, 32'd1);
    rst = 1'b1;
    cyc();
    rst     = 1'b0;
    tx_busy = 1'b0;
    chk("t6_tx_start", {31'd0, tx_start}, 32'd0);
    chk("t6_tx_data", {24'd0, tx_data}, 32'h00);
    chk("t6_grant", {31'd0, grant_id}, 32'd0);
    chk("t6_locked", {31'd0, locked}, 32'd0);
    chk("t6_timeout", {31'd0, timeout_err}, 32'd0);
    chk("t6_ready", {30'd0, req_ready}, 32'd0);
    req_valid = 2'b11;
    settle();
    chk("t6_ptr_reset", {30'd0, req_ready}, 32'd1);
    req_valid = 2'b00;
    cyc();
    chk("t6_no_stray_start", {31'd0, tx_start}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2: number of requesters sharing one UART transmitter.
REQ-002 Parameter BUSY_TIMEOUT, default 8: cycles allowed between tx_start and tx_busy rising.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  NUM_REQ  per-requester byte valid.
REQ-006 req_data  input  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
REQ-007 req_last  input  NUM_REQ  byte ends requester's packet; sampled with the byte.
REQ-008 req_ready  output  NUM_REQ  one-hot byte-accept strobe.
REQ-009 tx_start  output  1  one-cycle start pulse to the transmitter.
REQ-010 tx_data  output  8  byte to transmit; stable from tx_start until tx_done.
REQ-011 tx_busy  input  1  transmitter busy.
REQ-012 tx_done  input  1  transmitter completion pulse.
REQ-013 grant_id  output  clog2(NUM_REQ), min 1  current or last owner index.
REQ-014 locked  output  1  packet in progress; channel reserved for grant_id.
REQ-015 timeout_err  output  1  sticky; tx_busy not seen within BUSY_TIMEOUT.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-017 In IDLE and unlocked, the arbiter SHALL select the first requester with req_valid=1, searching round-robin from rr_ptr; req_ready SHALL be asserted combinationally for that requester only, in that cycle.
REQ-018 In IDLE and locked, only requester grant_id SHALL be eligible; others SHALL see req_ready=0.
REQ-019 A byte SHALL be accepted on a cycle with req_valid[i]=req_ready[i]=1; at that edge: latch tx_data and last-flag, set grant_id=i, go to ISSUE.
REQ-020 In ISSUE, tx_start SHALL be 1 for exactly one cycle, then go to WAIT_BUSY; req_ready SHALL be 0 in every state except IDLE.
REQ-021 In WAIT_BUSY: on tx_busy=1 go to WAIT_DONE; tx_done seen in WAIT_BUSY SHALL be ignored (stale pulse).
REQ-022 WAIT_BUSY SHALL count cycles; if BUSY_TIMEOUT cycles pass without tx_busy, set timeout_err=1, clear locked, advance rr_ptr to grant_id+1 (mod NUM_REQ), go to IDLE.
REQ-023 In WAIT_DONE, on tx_done=1 go to IDLE; if the byte had req_last=1, clear locked and set rr_ptr=grant_id+1 mod NUM_REQ; else set locked=1.
REQ-024 Latency: acceptance at edge t -> tx_start high in cycle t+1; next acceptance no earlier than the cycle after tx_done is seen.
REQ-025 A single-byte packet (req_last=1 on first byte) SHALL never assert locked.
REQ-026 Requester indices SHALL wrap modulo NUM_REQ; non-power-of-two NUM_REQ SHALL be supported.
REQ-027 Simultaneous req_valid from all requesters with rr_ptr=k SHALL grant k.
REQ-028 timeout_err SHALL clear only on rst.

Reset
REQ-029 On rst=1 at a clock edge: state=IDLE, req_ready=0, tx_start=0, tx_data=0, grant_id=0, rr_ptr=0, locked=0, timeout_err=0, counters=0.
REQ-030 Reset mid-byte SHALL abandon the byte and lock without further tx_start; transmitter recovery is outside this block.

Structure
REQ-031 FSM state encoding and default parameter values SHALL reside in a shared uart_pkg package.
REQ-032 Round-robin selection SHALL be a sub-module rr_select (inputs request vector, pointer; outputs one-hot grant, index, any).

Verification
REQ-033 Single byte: req_valid[0]=1, data 0x55, last=1 -> req_ready[0] same cycle, tx_start next cycle, tx_data=0x55, locked stays 0.
REQ-034 Contention: both valid, last=1, rr_ptr=0 -> grants 0 then 1 then 0 in byte order, each after the prior tx_done.
REQ-035 Packet lock: requester 1 sends 0xA1,0xA2,0xA3 (last on 0xA3) while requester 0 valid -> all three sent contiguously, requester 0 next.
REQ-036 Timeout: tx_busy held 0 -> timeout_err=1 exactly BUSY_TIMEOUT cycles after entering WAIT_BUSY, FSM in IDLE.
REQ-037 Stale done: tx_done=1 in first WAIT_BUSY cycle -> ignored; FSM waits for busy then a fresh done.
REQ-038 Reset in WAIT_DONE with locked=1 -> all outputs at reset values next cycle.
